// File: rtl/mul_unit.sv
// Iterative 32x32->64 multiply / multiply-accumulate unit (MUL/MLA/UMULL/UMLAL/SMULL/SMLAL), radix-2 shift-add.
// Latency: WIDTH+1 edges from the accepted start to the done edge; throughput one op per WIDTH+2 cycles.
// Backpressure: none; start is sampled only in IDLE, and a start while busy is dropped without queuing.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             accumulate,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int PW = 2 * WIDTH;

    // The iteration counter is 6 bits wide, which bounds WIDTH to 64.
    localparam logic [5:0]       LAST_CNT = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]    ONE_P    = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [5:0]       cnt;
    logic [WIDTH-1:0] mcand;      // |op_a| (or op_a when unsigned)
    logic [PW:0]      prod;       // 2W+1-bit partial product; low half starts as the multiplier
    logic             neg;        // final product must be negated
    logic             acc_en;     // accumulate captured at start
    logic [PW-1:0]    acc_val;    // {acc_hi, acc_lo} captured at start

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   upper_sum;
    logic [PW:0]      prod_step;
    logic [PW-1:0]    prod_mag;
    logic [PW-1:0]    prod_sgn;
    logic [PW-1:0]    final_p;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE waits for start, CALC runs WIDTH iterations, FINAL always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == LAST_CNT) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy covers CALC and FINAL, so it drops on the same edge done rises.
    always_comb begin
        busy = (state != IDLE);
    end

    // Operand magnitudes; the most negative value maps to itself and is then read as unsigned.
    always_comb begin
        mag_a = op_a;
        mag_b = op_b;
        if (is_signed && op_a[WIDTH-1]) mag_a = (~op_a) + ONE_W;
        if (is_signed && op_b[WIDTH-1]) mag_b = (~op_b) + ONE_W;
    end

    // One shift-add step: conditionally add the multiplicand to the upper half, then shift right by one.
    always_comb begin
        upper_sum = prod[PW:WIDTH] + {1'b0, mcand};
        if (prod[0]) begin
            prod_step = {1'b0, upper_sum, prod[WIDTH-1:1]};
        end else begin
            prod_step = {1'b0, prod[PW:1]};
        end
    end

    // Sign fix-up and optional accumulate of the finished magnitude product, all modulo 2^(2W).
    always_comb begin
        prod_mag = prod[PW-1:0];
        prod_sgn = neg ? ((~prod_mag) + ONE_P) : prod_mag;
        final_p  = acc_en ? (prod_sgn + acc_val) : prod_sgn;
    end

    // Datapath registers: capture in IDLE, iterate in CALC, publish result and flags in FINAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 6'd0;
            mcand     <= '0;
            prod      <= '0;
            neg       <= 1'b0;
            acc_en    <= 1'b0;
            acc_val   <= '0;
            done      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= 6'd0;
                        mcand   <= mag_a;
                        prod    <= {{(WIDTH+1){1'b0}}, mag_b};
                        neg     <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc_en  <= accumulate;
                        acc_val <= {acc_hi, acc_lo};
                    end
                end
                CALC: begin
                    prod <= prod_step;
                    cnt  <= cnt + 6'd1;
                end
                FINAL: begin
                    result_hi <= final_p[PW-1:WIDTH];
                    result_lo <= final_p[WIDTH-1:0];
                    flag_n    <= final_p[PW-1];
                    flag_z    <= (final_p == '0);
                    done      <= 1'b1;
                end
                default: begin
                    cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule
